id_ex_stage: RTL

- Pipeline register between decode and execute in the five-stage core.
- Captures the register-file read data (rsData/rtData) together with the decoded control and operand fields for the EX stage.
- Detects load-use hazards, stalls fetch/decode for one cycle and inserts a bubble.
- Provides a WB-to-ID bypass so a same-cycle register-file write is seen by the instruction being decoded.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/id_ex_stage_hazard_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word bit positions, widths and the bubble encoding.
// Used by the ID/EX register and by the hazard logic.
package pipe_pkg;

  localparam int CTRL_W = 8;
  localparam int REG_AW = 5;

  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int ALU_OP_HI       = 2;
  localparam int ALU_OP_LO       = 0;

  localparam logic [CTRL_W-1:0] BUBBLE = '0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detector: flags an ID instruction that reads the register an in-flight EX load writes.
// Purely combinational; index 0 is compared like any other register.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [AW-1:0] ex_rt,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rt,
  output logic          hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt && (ex_rt == id_rt);
  assign hazard   = ex_valid && ex_mem_read && id_valid && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID bypass and one-cycle load-use stall/bubble insertion.
// Latency one cycle; stall is combinational and holds PC and IF/ID upstream.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int D  = 32,
  localparam int AW = $clog2(D)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_rs,
  input  logic [AW-1:0]     id_rt,
  input  logic [AW-1:0]     id_rd,
  input  logic [N-1:0]      id_rs_data,
  input  logic [N-1:0]      id_rt_data,
  input  logic [N-1:0]      id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_uses_rt,
  input  logic              flush,
  input  logic              wb_write,
  input  logic [AW-1:0]     wb_rd,
  input  logic [N-1:0]      wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  output logic [AW-1:0]     ex_rd,
  output logic [N-1:0]      ex_rs_data,
  output logic [N-1:0]      ex_rt_data,
  output logic [N-1:0]      ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl
);

  ctrl_t      ex_ctrl_q;
  logic [N-1:0] rs_sel;
  logic [N-1:0] rt_sel;
  logic       hazard;

  // Register file writes in WB land after the ID read, so forward them here.
  assign rs_sel = (wb_write && (wb_rd == id_rs)) ? wb_data : id_rs_data;
  assign rt_sel = (wb_write && (wb_rd == id_rt)) ? wb_data : id_rt_data;

  hazard_detect #(.AW(AW)) u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_rt       (ex_rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .hazard      (hazard)
  );

  assign stall   = hazard && !flush;
  assign ex_ctrl = ex_ctrl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl_q  <= ctrl_t'(BUBBLE);
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
    end else if (flush || hazard) begin
      // Bubble; the stalled instruction is re-presented next cycle with a fresh bypass.
      ex_valid   <= 1'b0;
      ex_ctrl_q  <= ctrl_t'(BUBBLE);
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
    end else begin
      ex_valid   <= id_valid;
      ex_ctrl_q  <= id_valid ? ctrl_t'(id_ctrl) : ctrl_t'(BUBBLE);
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rs_data <= rs_sel;
      ex_rt_data <= rt_sel;
      ex_imm     <= id_imm;
    end
  end

endmodule
